// File: rtl/riscv_memory_pipe.sv
// EX->WB memory-stage register chain. STAGES slots carry PC, instruction, result,
// data address and exception vector. Empty slots can collapse under stall, and an exception flush is supported.
module riscv_memory_pipe #(
  parameter int                XLEN             = 64,
  parameter int                ILEN             = 64,
  parameter int                EXCEPTION_SIZE   = 16,
  parameter logic [XLEN-1:0]   PC_INIT          = 'h8000_0000,
  parameter int                STAGES           = 2,
  parameter int                COLLAPSE_BUBBLES = 1,
  localparam int               OCC_W            = $clog2(STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic                      ex_bubble,
  input  logic [ILEN-1:0]           ex_instr,
  input  logic [EXCEPTION_SIZE-1:0] ex_exception,
  input  logic [XLEN-1:0]           ex_r,
  input  logic [XLEN-1:0]           dmem_adr,
  input  logic [EXCEPTION_SIZE-1:0] wb_exception,
  output logic                      ex_ready,
  output logic [XLEN-1:0]           mem_pc,
  output logic                      mem_bubble,
  output logic [ILEN-1:0]           mem_instr,
  output logic [EXCEPTION_SIZE-1:0] mem_exception,
  output logic [XLEN-1:0]           mem_r,
  output logic [XLEN-1:0]           mem_memadr,
  output logic [OCC_W-1:0]          mem_occupancy
);

  logic [STAGES-1:0]         valid_q, valid_d;
  logic [XLEN-1:0]           pc_q    [STAGES];
  logic [XLEN-1:0]           pc_d    [STAGES];
  logic [ILEN-1:0]           instr_q [STAGES];
  logic [ILEN-1:0]           instr_d [STAGES];
  logic [EXCEPTION_SIZE-1:0] exc_q   [STAGES];
  logic [EXCEPTION_SIZE-1:0] exc_d   [STAGES];
  logic [XLEN-1:0]           r_q     [STAGES];
  logic [XLEN-1:0]           r_d     [STAGES];
  logic [XLEN-1:0]           adr_q   [STAGES];
  logic [XLEN-1:0]           adr_d   [STAGES];
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [STAGES-1:0]         adv;
  logic                      flush;

  // Advance enables. In collapse mode, stage i moves when any stage from i up to
  // the one before the output stage is empty, or WB takes the output stage.
  always_comb begin : adv_calc
    logic run;
    adv = '0;
    run = !wb_stall;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (i < STAGES - 1 && COLLAPSE_BUBBLES != 0) run = run | !valid_q[i];
      adv[i] = run;
    end
  end

  assign flush    = (valid_q[STAGES-1] & |exc_q[STAGES-1]) | |wb_exception;
  assign ex_ready = adv[0] & !flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    r_d     = r_q;
    adr_d   = adr_q;
    occ_d   = '0;
    for (int i = 0; i < STAGES; i++) begin
      int j;
      j = (i == 0) ? 0 : i - 1;
      if (flush) begin
        // Flush kills slots but leaves payload in place.
        valid_d[i] = 1'b0;
        exc_d[i]   = '0;
      end else if (adv[i]) begin
        if (i == 0) begin
          valid_d[i] = !ex_bubble;
          pc_d[i]    = ex_pc;
          instr_d[i] = ex_instr;
          exc_d[i]   = ex_bubble ? '0 : ex_exception;
          r_d[i]     = ex_r;
          adr_d[i]   = dmem_adr;
        end else begin
          valid_d[i] = valid_q[j];
          pc_d[i]    = pc_q[j];
          instr_d[i] = instr_q[j];
          exc_d[i]   = valid_q[j] ? exc_q[j] : '0;
          r_d[i]     = r_q[j];
          adr_d[i]   = adr_q[j];
        end
      end
    end
    for (int i = 0; i < STAGES; i++) occ_d = occ_d + OCC_W'(valid_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i]    <= PC_INIT;
        instr_q[i] <= '0;
        exc_q[i]   <= '0;
        r_q[i]     <= '0;
        adr_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      r_q     <= r_d;
      adr_q   <= adr_d;
    end
  end

  assign mem_pc        = pc_q[STAGES-1];
  assign mem_bubble    = !valid_q[STAGES-1];
  assign mem_instr     = instr_q[STAGES-1];
  assign mem_exception = exc_q[STAGES-1];
  assign mem_r         = r_q[STAGES-1];
  assign mem_memadr    = adr_q[STAGES-1];
  assign mem_occupancy = occ_q;

endmodule

// File: tb/tb_riscv_memory_pipe.sv
// Bench for riscv_memory_pipe: three instances (2-stage collapse, 3-stage collapse,
// 2-stage lock-step) share stimulus; table vectors, hand sequences and a scoreboard.
module tb_riscv_memory_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic [63:0] ex_pc;
  logic        ex_bubble;
  logic [63:0] ex_instr;
  logic [15:0] ex_exception;
  logic [63:0] ex_r;
  logic [63:0] dmem_adr;
  logic [15:0] wb_exception;

  logic        a_ready, a_bubble;
  logic [63:0] a_pc, a_instr, a_r, a_adr;
  logic [15:0] a_exc;
  logic [1:0]  a_occ;
  logic        b_ready, b_bubble;
  logic [63:0] b_pc, b_instr, b_r, b_adr;
  logic [15:0] b_exc;
  logic [1:0]  b_occ;
  logic        c_ready, c_bubble;
  logic [63:0] c_pc, c_instr, c_r, c_adr;
  logic [15:0] c_exc;
  logic [1:0]  c_occ;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  riscv_memory_pipe #(.STAGES(2), .COLLAPSE_BUBBLES(1)) u_s2c (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .ex_pc(ex_pc), .ex_bubble(ex_bubble),
    .ex_instr(ex_instr), .ex_exception(ex_exception), .ex_r(ex_r), .dmem_adr(dmem_adr),
    .wb_exception(wb_exception), .ex_ready(a_ready), .mem_pc(a_pc), .mem_bubble(a_bubble),
    .mem_instr(a_instr), .mem_exception(a_exc), .mem_r(a_r), .mem_memadr(a_adr),
    .mem_occupancy(a_occ));

  riscv_memory_pipe #(.STAGES(3), .COLLAPSE_BUBBLES(1)) u_s3 (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .ex_pc(ex_pc), .ex_bubble(ex_bubble),
    .ex_instr(ex_instr), .ex_exception(ex_exception), .ex_r(ex_r), .dmem_adr(dmem_adr),
    .wb_exception(wb_exception), .ex_ready(b_ready), .mem_pc(b_pc), .mem_bubble(b_bubble),
    .mem_instr(b_instr), .mem_exception(b_exc), .mem_r(b_r), .mem_memadr(b_adr),
    .mem_occupancy(b_occ));

  riscv_memory_pipe #(.STAGES(2), .COLLAPSE_BUBBLES(0)) u_s2l (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .ex_pc(ex_pc), .ex_bubble(ex_bubble),
    .ex_instr(ex_instr), .ex_exception(ex_exception), .ex_r(ex_r), .dmem_adr(dmem_adr),
    .wb_exception(wb_exception), .ex_ready(c_ready), .mem_pc(c_pc), .mem_bubble(c_bubble),
    .mem_instr(c_instr), .mem_exception(c_exc), .mem_r(c_r), .mem_memadr(c_adr),
    .mem_occupancy(c_occ));

  always #5 clk = ~clk;

  // Payload fields are fixed functions of the PC so any slot can be checked from its PC.
  function automatic logic [63:0] f_instr(input logic [63:0] pc);
    return pc ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction
  function automatic logic [63:0] f_r(input logic [63:0] pc);
    return ~pc;
  endfunction
  function automatic logic [63:0] f_adr(input logic [63:0] pc);
    return pc + 64'h1000;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic set_in(input logic bub, input logic [63:0] pc, input logic [15:0] exc,
                        input logic stall, input logic [15:0] wbx);
    ex_bubble    = bub;
    ex_pc        = pc;
    ex_instr     = f_instr(pc);
    ex_r         = f_r(pc);
    dmem_adr     = f_adr(pc);
    ex_exception = exc;
    wb_stall     = stall;
    wb_exception = wbx;
  endtask

  // One cycle on the 3-stage instance with scoreboard bookkeeping.
  task automatic s3_cycle(input logic bub, input logic [63:0] pc, input logic stall);
    logic [63:0] e;
    set_in(bub, pc, 16'h0, stall, 16'h0);
    @(negedge clk);
    if (!b_bubble && !stall) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", b_pc, e);
        chk("sb_instr", b_instr, f_instr(e));
        chk("sb_r", b_r, f_r(e));
        chk("sb_adr", b_adr, f_adr(e));
      end
    end
    if (!bub && b_ready) exp_q.push_back(pc);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        bub;
    logic [63:0] pc;
    logic [15:0] exc;
    logic        stall;
    logic [15:0] wbx;
    logic        e_ready;
    logic        e_bubble;
    logic        chk_pc;
    logic [63:0] e_pc;
    logic [15:0] e_exc;
    logic [1:0]  e_occ;
  } vec_t;

  function automatic vec_t mk(input logic bub, input logic [63:0] pc, input logic [15:0] exc,
                              input logic stall, input logic [15:0] wbx, input logic e_ready,
                              input logic e_bubble, input logic chk_pc, input logic [63:0] e_pc,
                              input logic [15:0] e_exc, input logic [1:0] e_occ);
    vec_t v;
    v.bub = bub; v.pc = pc; v.exc = exc; v.stall = stall; v.wbx = wbx;
    v.e_ready = e_ready; v.e_bubble = e_bubble; v.chk_pc = chk_pc;
    v.e_pc = e_pc; v.e_exc = e_exc; v.e_occ = e_occ;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    // Expectations for the 2-stage collapsing instance; checked mid-cycle.
    tbl[0]  = mk(0, 64'h200, 0, 0, 0, 1, 1, 1, 64'h8000_0000, 0, 0);
    tbl[1]  = mk(1, 64'h0,   0, 0, 0, 1, 1, 1, 64'h8000_0000, 0, 1);
    tbl[2]  = mk(0, 64'h204, 0, 1, 0, 1, 0, 1, 64'h200, 0, 1);
    tbl[3]  = mk(0, 64'h208, 0, 1, 0, 0, 0, 1, 64'h200, 0, 2);
    tbl[4]  = mk(0, 64'h208, 0, 0, 0, 1, 0, 1, 64'h200, 0, 2);
    tbl[5]  = mk(1, 64'h0,   0, 0, 0, 1, 0, 1, 64'h204, 0, 2);
    tbl[6]  = mk(1, 64'h0,   0, 0, 0, 1, 0, 1, 64'h208, 0, 1);
    tbl[7]  = mk(0, 64'h300, 4, 0, 0, 1, 1, 0, 64'h0, 0, 0);
    tbl[8]  = mk(0, 64'h304, 0, 0, 0, 1, 1, 0, 64'h0, 0, 1);
    tbl[9]  = mk(0, 64'h308, 0, 0, 0, 0, 0, 1, 64'h300, 4, 2);
    tbl[10] = mk(1, 64'h0,   0, 0, 0, 1, 1, 1, 64'h300, 0, 0);
    tbl[11] = mk(0, 64'h400, 0, 0, 0, 1, 1, 0, 64'h0, 0, 0);
    tbl[12] = mk(0, 64'h404, 0, 0, 0, 1, 1, 0, 64'h0, 0, 1);
    tbl[13] = mk(0, 64'h408, 0, 1, 1, 0, 0, 1, 64'h400, 0, 2);
    tbl[14] = mk(1, 64'h0,   0, 1, 0, 1, 1, 1, 64'h400, 0, 0);
    tbl[15] = mk(1, 64'h0,   8, 0, 0, 1, 1, 1, 64'h400, 0, 0);
    tbl[16] = mk(1, 64'h0,   0, 0, 0, 1, 1, 0, 64'h0, 0, 0);
    tbl[17] = mk(1, 64'h0,   0, 0, 0, 1, 1, 0, 64'h0, 0, 0);

    // Reset values
    rst = 1'b1;
    set_in(1, 64'h0, 0, 0, 0);
    @(negedge clk);
    chk("rst_bubble", {63'd0, a_bubble}, 64'd1);
    chk("rst_pc", a_pc, 64'h8000_0000);
    chk("rst_occ", {62'd0, a_occ}, 64'd0);
    chk("rst_ready", {63'd0, a_ready}, 64'd1);
    chk("rst_instr", a_instr, 64'd0);
    chk("rst_r", a_r | a_adr | {48'd0, a_exc}, 64'd0);
    chk("rst_s3_pc", b_pc, 64'h8000_0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-stream asynchronous reset with two valid stages
    set_in(0, 64'h300, 0, 0, 0);
    @(posedge clk); #1;
    set_in(0, 64'h304, 0, 0, 0);
    @(posedge clk); #1;
    set_in(1, 64'h0, 0, 0, 0);
    chk("t1_pre_occ", {62'd0, a_occ}, 64'd2);
    chk("t1_pre_pc", a_pc, 64'h300);
    rst = 1'b1;
    #1;
    chk("t1_bubble", {63'd0, a_bubble}, 64'd1);
    chk("t1_pc", a_pc, 64'h8000_0000);
    chk("t1_occ", {62'd0, a_occ}, 64'd0);
    chk("t1_s3_occ", {62'd0, b_occ}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors: collapse, stall hold, exception flush, wb_exception flush
    for (int k = 0; k < 18; k++) begin
      set_in(tbl[k].bub, tbl[k].pc, tbl[k].exc, tbl[k].stall, tbl[k].wbx);
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), {63'd0, a_ready}, {63'd0, tbl[k].e_ready});
      chk($sformatf("v%0d_bubble", k), {63'd0, a_bubble}, {63'd0, tbl[k].e_bubble});
      chk($sformatf("v%0d_exc", k), {48'd0, a_exc}, {48'd0, tbl[k].e_exc});
      chk($sformatf("v%0d_occ", k), {62'd0, a_occ}, {62'd0, tbl[k].e_occ});
      if (tbl[k].chk_pc) chk($sformatf("v%0d_pc", k), a_pc, tbl[k].e_pc);
      if (tbl[k].chk_pc && !tbl[k].e_bubble) begin
        chk($sformatf("v%0d_instr", k), a_instr, f_instr(tbl[k].e_pc));
        chk($sformatf("v%0d_adr", k), a_adr, f_adr(tbl[k].e_pc));
      end
      // Lock-step instance sees the same stimulus: frozen while stalled
      if (k == 2 || k == 3) begin
        chk($sformatf("ls%0d_ready", k), {63'd0, c_ready}, 64'd0);
        chk($sformatf("ls%0d_pc", k), c_pc, 64'h200);
        chk($sformatf("ls%0d_occ", k), {62'd0, c_occ}, 64'd1);
      end else if (k == 4) begin
        chk("ls4_ready", {63'd0, c_ready}, 64'd1);
        chk("ls4_pc", c_pc, 64'h200);
      end else if (k == 5) begin
        chk("ls5_bubble", {63'd0, c_bubble}, 64'd1);
        chk("ls5_occ", {62'd0, c_occ}, 64'd1);
      end
      @(posedge clk); #1;
    end

    for (int k = 0; k < 5; k++) begin
      set_in(1, 64'h0, 0, 0, 0);
      @(posedge clk); #1;
    end

    // Three-stage latency: accepted at edge N, visible after edge N+2
    s3_cycle(0, 64'h100, 0);
    chk("t2_n0_bubble", {63'd0, b_bubble}, 64'd1);
    s3_cycle(0, 64'h104, 0);
    chk("t2_n1_bubble", {63'd0, b_bubble}, 64'd1);
    chk("t2_n1_occ", {62'd0, b_occ}, 64'd2);
    s3_cycle(0, 64'h108, 0);
    chk("t2_n2_pc", b_pc, 64'h100);
    chk("t2_n2_occ", {62'd0, b_occ}, 64'd3);
    s3_cycle(1, 64'h0, 0);
    chk("t2_n3_pc", b_pc, 64'h104);
    s3_cycle(1, 64'h0, 0);
    chk("t2_n4_pc", b_pc, 64'h108);
    chk("t2_n4_occ", {62'd0, b_occ}, 64'd1);
    s3_cycle(1, 64'h0, 0);
    chk("t2_n5_bubble", {63'd0, b_bubble}, 64'd1);
    chk("t2_n5_occ", {62'd0, b_occ}, 64'd0);

    // Random bubbles and stalls through the 3-stage chain
    for (int k = 0; k < 300; k++) begin
      s3_cycle($urandom_range(0, 2) == 0, {32'd0, $urandom}, $urandom_range(0, 3) == 0);
    end
    for (int k = 0; k < 8; k++) s3_cycle(1, 64'h0, 0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("sb_end_occ", {62'd0, b_occ}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
